// File: rtl/iter_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : iter_alu_pkg
// Brief   : Opcode and FSM state encodings shared by the iterative ALU.
// Revision: 1.0 - initial release
// ============================================================================
package iter_alu_pkg;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/iter_alu_if.sv
`default_nettype none
// ============================================================================
// Module  : iter_alu_if
// Brief   : Request/response handshake bundle between producer and iterative ALU.
// Revision: 1.0 - initial release
// ============================================================================
interface iter_alu_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [2:0]       select;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, data1, data2, select, out_ready,
    input  in_ready, out_valid, result, zero, carry, overflow
  );

  modport slave (
    input  in_valid, data1, data2, select, out_ready,
    output in_ready, out_valid, result, zero, carry, overflow
  );

endinterface
`default_nettype wire

// File: rtl/iter_alu_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module  : shift_add_mult
// Brief   : Iterative shift-add multiplier, one partial product per step.
// Revision: 1.0 - initial release
// ============================================================================
module shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               load,
  input  wire logic               step,
  input  wire logic [WIDTH-1:0]   a,
  input  wire logic [WIDTH-1:0]   b,
  output logic      [2*WIDTH-1:0] acc_next
);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;

  // acc_next is the value after the current step, so the caller can register
  // the full product on the same edge as the final step.
  assign acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (load) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
    end else if (step) begin
      r_acc    <= acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/iter_alu.sv
`default_nettype none
// ============================================================================
// Module  : iter_alu
// Brief   : Multi-cycle ALU: single-step logic/add, bit-serial shifts, shift-add MUL.
// Revision: 1.0 - initial release
// ============================================================================
module iter_alu
  import iter_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input wire logic clk,
  input wire logic reset,
  iter_alu_if.slave bus
);

  localparam int             CW          = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  c_width     = CW'(WIDTH);
  localparam logic [CW-1:0]  c_one       = CW'(1);
  localparam logic [WIDTH:0] c_width_ext = (WIDTH + 1)'(WIDTH);

  state_t r_state;
  state_t w_state_nxt;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_last;
  logic               w_mul_step;
  logic               w_ge;
  logic [CW-1:0]      w_n;
  logic [CW-1:0]      w_steps;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_sh_nxt;
  logic [WIDTH-1:0]   w_res;
  logic [2*WIDTH-1:0] w_acc;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2:0]         r_op;
  logic [CW-1:0]      r_cnt;
  logic               r_noshift;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_carry;
  logic               r_ovf;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept   = w_in_ready & bus.in_valid;
  assign w_last     = (r_state == S_EXEC) && (r_cnt == c_one);
  assign w_mul_step = (r_state == S_EXEC) && (r_op == OP_MUL);

  // Shift distance saturates at WIDTH; a zero distance still costs one step.
  assign w_ge = {1'b0, bus.data2} >= c_width_ext;
  assign w_n  = w_ge ? c_width : bus.data2[CW-1:0];

  always_comb begin
    w_steps = c_one;
    case (bus.select)
      OP_SLL, OP_SRL, OP_SRA: w_steps = (w_n == '0) ? c_one : w_n;
      OP_MUL:                 w_steps = c_width;
      default:                w_steps = c_one;
    endcase
  end

  assign w_sum = {1'b0, r_a} + {1'b0, r_b};

  always_comb begin
    w_sh_nxt = r_a;
    if (!r_noshift) begin
      case (r_op)
        OP_SLL:  w_sh_nxt = {r_a[WIDTH-2:0], 1'b0};
        OP_SRL:  w_sh_nxt = {1'b0, r_a[WIDTH-1:1]};
        OP_SRA:  w_sh_nxt = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
        default: w_sh_nxt = r_a;
      endcase
    end
  end

  always_comb begin
    w_res = '0;
    case (r_op)
      OP_FWD:                 w_res = r_b;
      OP_ADD:                 w_res = w_sum[WIDTH-1:0];
      OP_AND:                 w_res = r_a & r_b;
      OP_OR:                  w_res = r_a | r_b;
      OP_SLL, OP_SRL, OP_SRA: w_res = w_sh_nxt;
      OP_MUL:                 w_res = w_acc[WIDTH-1:0];
      default:                w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= OP_FWD;
      r_cnt     <= '0;
      r_noshift <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_carry   <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_a       <= bus.data1;
      r_b       <= bus.data2;
      r_op      <= bus.select;
      r_cnt     <= w_steps;
      r_noshift <= (w_n == '0);
    end else if (r_state == S_EXEC) begin
      if (is_shift(r_op)) r_a <= w_sh_nxt;
      if (!w_last) begin
        r_cnt <= r_cnt - c_one;
      end else begin
        r_result <= w_res;
        r_zero   <= (w_res == '0);
        r_carry  <= (r_op == OP_ADD) & w_sum[WIDTH];
        r_ovf    <= (r_op == OP_MUL) & (|w_acc[2*WIDTH-1:WIDTH]);
      end
    end
  end

  shift_add_mult #(
    .WIDTH (WIDTH)
  ) u_mult (
    .clk      (clk),
    .reset    (reset),
    .load     (w_accept),
    .step     (w_mul_step),
    .a        (bus.data1),
    .b        (bus.data2),
    .acc_next (w_acc)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.carry     = r_carry;
  assign bus.overflow  = r_ovf;

endmodule
`default_nettype wire
